nibble_serial_adder: RTL and testbench

- Multi-cycle WIDTH-bit adder that streams operands 4 bits per cycle through one combinational 4-bit carry-lookahead slice.
- The slice is the existing carry_look_ahead_gen (ports a[3:0], b[3:0], cin, sum[3:0], carry). This block feeds its operand nibbles and consumes its sum and carry.
- Carry is registered between nibbles. Operands enter and results leave through valid/ready handshakes.
- Sits between operand sources and datapath consumers that trade latency for area.

---
 rtl/nibble_serial_adder.sv | 182 ++++++++++++++++++
 tb/tb_nibble_serial_adder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that streams operands 4 bits per cycle through one 4-bit carry-lookahead slice.
// Optional signed-overflow output is enabled by defining NIBBLE_SERIAL_ADDER_OVF_EN.

module carry_look_ahead_gen (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       carry
);
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  always_comb begin
    g     = a & b;
    p     = a ^ b;
    c[0]  = cin;
    c[1]  = g[0] | (p[0] & cin);
    c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    carry = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & cin);
    sum   = p ^ c;
  end
endmodule

module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);
  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic               ovf_q, ovf_d;
`endif

  logic [3:0]         slice_sum;
  logic               slice_carry;
  logic [WIDTH+3:0]   sum_cat;
  logic [WIDTH-1:0]   sum_shift;
  logic               last_nib;

  carry_look_ahead_gen u_slice (
    .a     (a_sh_q[3:0]),
    .b     (b_sh_q[3:0]),
    .cin   (carry_q),
    .sum   (slice_sum),
    .carry (slice_carry)
  );

  // New nibble enters sum_sh from the top; works for WIDTH=4 as well.
  assign sum_cat   = {slice_sum, sum_sh_q};
  assign sum_shift = sum_cat[WIDTH+3:4];
  assign last_nib  = (cnt_q == CNT_W'(NIBBLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 4;
        b_sh_d   = b_sh_q >> 4;
        sum_sh_d = sum_shift;
        carry_d  = slice_carry;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_nib) begin
          sum_d   = sum_shift;
          cout_d  = slice_carry;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
          ovf_d   = (a_msb_q == b_msb_q) && (sum_shift[WIDTH-1] != a_msb_q);
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WIDTH=16); ovf checks follow NIBBLE_SERIAL_ADDER_OVF_EN.

module tb_nibble_serial_adder;
  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Present operands and return #1 after the accepting edge.
  task automatic accept(input string tag, input logic [15:0] xa, input logic [15:0] xb, input logic xc);
    int g;
    @(negedge clk);
    a = xa; b = xb; cin = xc; in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) check({tag, "_accept_timeout"}, 32'(g), 32'(0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Waits for out_valid counting edges since acceptance, then checks the result.
  task automatic wait_result(input string tag, input int exp_lat, input logic [15:0] esum,
                             input logic ecout, input logic eovf);
    int lat;
    int stray;
    lat = 0;
    stray = 0;
    while (!out_valid && lat < 50) begin
      if (in_ready || !busy) stray++;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_ready_busy_in_run"}, 32'(stray), 32'(0));
    check({tag, "_sum"}, 32'(sum), 32'(esum));
    check({tag, "_cout"}, 32'(cout), 32'(ecout));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(eovf));
`else
    if (eovf !== 1'b0 && eovf !== 1'b1) check({tag, "_eovf_x"}, 32'(eovf), 32'(0));
`endif
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_idle_in_ready"}, 32'(in_ready), 32'(1));
    check({tag, "_idle_out_valid"}, 32'(out_valid), 32'(0));
    out_ready = 1'b0;
  endtask

  task automatic run_add(input string tag, input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                         input logic [15:0] esum, input logic ecout, input logic eovf, input bit rel);
    accept(tag, xa, xb, xc);
    check({tag, "_busy"}, 32'(busy), 32'(1));
    wait_result(tag, 4, esum, ecout, eovf);
    if (rel) release_result(tag);
  endtask

  int unsigned acc_cyc [3];
  logic [15:0] bb_a    [3] = '{16'h0F0F, 16'h8000, 16'hABCD};
  logic [15:0] bb_b    [3] = '{16'h00F1, 16'h8000, 16'h1111};
  logic        bb_c    [3] = '{1'b0, 1'b0, 1'b1};
  logic [15:0] bb_s    [3] = '{16'h1000, 16'h0000, 16'hBCDF};
  logic        bb_co   [3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_sum", 32'(sum), 32'(0));
    check("rst_cout", 32'(cout), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    run_add("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1);
    run_add("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1);
    run_add("cin_only", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1);

    // Back-pressure: result held, new operands refused until handoff.
    run_add("bp", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0);
    @(negedge clk);
    a = 16'h0102; b = 16'h0304; cin = 1'b0; in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("bp_hold_sum", 32'(sum), 32'(16'hFFFF));
      check("bp_hold_cout", 32'(cout), 32'(1));
      check("bp_hold_in_ready", 32'(in_ready), 32'(0));
      check("bp_hold_out_valid", 32'(out_valid), 32'(1));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_rel_in_ready", 32'(in_ready), 32'(1));
    check("bp_rel_out_valid", 32'(out_valid), 32'(0));
    @(negedge clk);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_new_busy", 32'(busy), 32'(1));
    wait_result("bp_new", 4, 16'h0406, 1'b0, 1'b0);
    release_result("bp_new");

    // Asynchronous reset two cycles into a run.
    accept("rst_mid", 16'hAAAA, 16'h5555, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rstmid_in_ready", 32'(in_ready), 32'(1));
    check("rstmid_out_valid", 32'(out_valid), 32'(0));
    check("rstmid_sum", 32'(sum), 32'(0));
    check("rstmid_cout", 32'(cout), 32'(0));
    check("rstmid_busy", 32'(busy), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_add("after_rst", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1);

    // Back-to-back with out_ready tied high and in_valid held.
    out_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      int g;
      @(negedge clk);
      g = 0;
      while (!in_ready && g < 50) begin
        @(negedge clk);
        g++;
      end
      if (g >= 50) check("b2b_accept_timeout", 32'(g), 32'(0));
      a = bb_a[t]; b = bb_b[t]; cin = bb_c[t]; in_valid = 1'b1;
      @(posedge clk);
      #1;
      acc_cyc[t] = cyc;
      repeat (4) @(posedge clk);
      #1;
      check("b2b_out_valid", 32'(out_valid), 32'(1));
      check("b2b_sum", 32'(sum), 32'(bb_s[t]));
      check("b2b_cout", 32'(cout), 32'(bb_co[t]));
    end
    in_valid = 1'b0;
    check("b2b_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'(6));
    check("b2b_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'(6));
    @(negedge clk);
    out_ready = 1'b0;
    @(posedge clk);
    #1;

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    run_add("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1);
    run_add("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1);
    run_add("ovf_none", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
